// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding, default sizes and width helper for the sequencer
package seq_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, SAMPLE, DONE} state_t;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIV = 4;
  localparam int DEF_CNT_W = 5;
  function automatic int tick_w(input int div);
    return div > 1 ? $clog2(div) : 1;
  endfunction
endpackage

// File: rtl/seq_stream_ctrl_tick_gen.sv
// tick_gen: clock-enable divider giving a one-cycle registered strobe every DIV running cycles
module tick_gen
  import seq_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int TW = tick_w(DIV);
  localparam logic [TW-1:0] LAST = TW'(DIV - 1);
  logic [TW-1:0] cnt;
  logic [TW-1:0] cnt_next;
  always_comb cnt_next = clr || cnt == LAST ? '0 : cnt + 1'b1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      tick <= 1'b0;
    end else begin
      cnt <= en ? cnt_next : '0;
      tick <= en && cnt_next == LAST;
    end
endmodule

// File: rtl/seq_stream_ctrl.sv
// seq_stream_ctrl: serialises a latched pattern into the sequence detector and counts its hits
module seq_stream_ctrl
  import seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV = DEF_DIV,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic             det_b,
  output logic             seq_out,
  output logic             seq_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_count
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  state_t state;
  state_t state_next;
  logic [WIDTH-1:0] sr;
  logic [BW-1:0] bit_cnt;
  logic sample;
  logic accept;
  logic last;
  assign seq_out = sr[WIDTH-1];
  always_comb begin
    accept = state == IDLE && start;
    last = seq_en && bit_cnt == LAST_BIT;
    state_next = state == IDLE ? (start ? SHIFT : IDLE) :
                 state == SHIFT ? (last ? SAMPLE : SHIFT) :
                 state == SAMPLE ? DONE : IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sr <= '0;
      bit_cnt <= '0;
      sample <= 1'b0;
      hit_count <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      sr <= accept ? pattern : seq_en ? sr << 1 : sr;
      bit_cnt <= accept ? '0 : seq_en ? bit_cnt + 1'b1 : bit_cnt;
      sample <= seq_en;
      hit_count <= accept ? '0 : sample && det_b && !(&hit_count) ? hit_count + 1'b1 : hit_count;
      busy <= state_next == SHIFT || state_next == SAMPLE;
      done <= state_next == DONE;
    end
  tick_gen #(.DIV(DIV)) u_tick (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .en(state_next == SHIFT),
    .tick(seq_en)
  );
endmodule

// File: tb/tb_seq_stream_ctrl.sv
// tb_seq_stream_ctrl: scoreboard bench for seq_stream_ctrl over three parameter sets
`timescale 1ns/1ps
module tb_seq_stream_ctrl;
  localparam int W = 16;
  typedef struct {
    int inst;
    int hits;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] start = '0;
  logic [W-1:0] pattern [3];
  logic [2:0] det = '0;
  logic [2:0] dsh [3];
  logic [2:0] seq_out;
  logic [2:0] seq_en;
  logic [2:0] busy;
  logic [2:0] done;
  logic [4:0] hc0;
  logic [4:0] hc1;
  logic [1:0] hc2;
  exp_t q[$];
  exp_t e;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int k = 0;
  int e0 = 0;
  int cur = 0;
  int stray = 0;
  int done_cnt = 0;
  int runs = 0;
  bit active = 1'b0;
  logic [W-1:0] cur_pat = '0;
  seq_stream_ctrl #(.WIDTH(16), .DIV(4), .CNT_W(5)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .pattern(pattern[0]), .det_b(det[0]),
    .seq_out(seq_out[0]), .seq_en(seq_en[0]), .busy(busy[0]), .done(done[0]), .hit_count(hc0)
  );
  seq_stream_ctrl #(.WIDTH(16), .DIV(1), .CNT_W(5)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .pattern(pattern[1]), .det_b(det[1]),
    .seq_out(seq_out[1]), .seq_en(seq_en[1]), .busy(busy[1]), .done(done[1]), .hit_count(hc1)
  );
  seq_stream_ctrl #(.WIDTH(16), .DIV(2), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .pattern(pattern[2]), .det_b(det[2]),
    .seq_out(seq_out[2]), .seq_en(seq_en[2]), .busy(busy[2]), .done(done[2]), .hit_count(hc2)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    for (int i = 0; i < 3; i++)
      if (!busy[i]) begin
        dsh[i] <= '0;
        det[i] <= 1'b0;
      end else if (seq_en[i]) begin
        dsh[i] <= {dsh[i][1:0], seq_out[i]};
        det[i] <= {dsh[i], seq_out[i]} == 4'b1101;
      end
  function automatic int div_of(int i);
    return i == 0 ? 4 : i == 1 ? 1 : 2;
  endfunction
  function automatic int cw_of(int i);
    return i == 2 ? 2 : 5;
  endfunction
  function automatic int hc_of(int i);
    return i == 0 ? int'(hc0) : i == 1 ? int'(hc1) : int'(hc2);
  endfunction
  function automatic int exp_hits(logic [W-1:0] p, int cw);
    logic [3:0] h = '0;
    int n = 0;
    for (int b = W - 1; b >= 0; b--) begin
      h = {h[2:0], p[b]};
      n += h == 4'b1101 ? 1 : 0;
    end
    return n > (1 << cw) - 1 ? (1 << cw) - 1 : n;
  endfunction
  task automatic check(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    for (int i = 0; i < 3; i++) begin
      if (seq_en[i]) begin
        if (!active || i != cur || k >= W) stray++;
        else begin
          k++;
          check("en_cyc", cyc, e0 + k * div_of(i));
          check("seq_out", int'(seq_out[i]), int'(cur_pat[W-k]));
        end
      end
      if (done[i]) begin
        done_cnt++;
        if (q.size() == 0) check("spurious_done", 1, 0);
        else begin
          e = q.pop_front();
          check("done_inst", i, e.inst);
          check("done_cyc", cyc, e.cyc);
          check("hits", hc_of(i), e.hits);
          check("en_count", k, W);
          check("busy_at_done", int'(busy[i]), 0);
          active = 1'b0;
        end
      end
    end
  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_cyc(int t);
    while (cyc < t) tick(1);
  endtask
  task automatic wait_idle(int budget);
    for (int n = 0; n < budget && active; n++) tick(1);
    if (active) begin
      check("timeout", 0, 1);
      active = 1'b0;
    end
  endtask
  task automatic start_run(int i, logic [W-1:0] p);
    exp_t n;
    tick(1);
    start[i] = 1'b1;
    pattern[i] = p;
    cur = i;
    cur_pat = p;
    e0 = cyc;
    k = 0;
    active = 1'b1;
    runs++;
    n.inst = i;
    n.hits = exp_hits(p, cw_of(i));
    n.cyc = e0 + W * div_of(i) + 2;
    q.push_back(n);
    tick(1);
    start[i] = 1'b0;
    pattern[i] = '0;
    check("busy_after_accept", int'(busy[i]), 1);
    check("clr_at_accept", hc_of(i), 0);
  endtask
  task automatic poke(int i);
    start[i] = 1'b1;
    pattern[i] = 16'hFFFF;
    tick(1);
    start[i] = 1'b0;
    pattern[i] = '0;
  endtask
  initial begin
    for (int i = 0; i < 3; i++) pattern[i] = '0;
    #1 rst = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      check("rst_seq_out", int'(seq_out[i]), 0);
      check("rst_seq_en", int'(seq_en[i]), 0);
      check("rst_busy", int'(busy[i]), 0);
      check("rst_done", int'(done[i]), 0);
      check("rst_hits", hc_of(i), 0);
    end
    tick(20);
    start_run(0, 16'hDB6D);
    wait_cyc(e0 + 20);
    poke(0);
    wait_cyc(e0 + 66);
    poke(0);
    wait_idle(200);
    tick(4);
    check("hold_idle", int'(hc0), 5);
    check("busy_idle", int'(busy[0]), 0);
    start_run(0, 16'hDDDD);
    wait_idle(200);
    start_run(1, 16'hDB6D);
    wait_idle(200);
    start_run(2, 16'hDB6D);
    wait_idle(200);
    tick(5);
    check("sat_hold", int'(hc2), 3);
    start_run(0, 16'hDB6D);
    wait_cyc(e0 + 27);
    check("pre_abort_hits", int'(hc0), 1);
    tick(1);
    rst = 1'b0;
    active = 1'b0;
    q.delete();
    runs--;
    tick(1);
    check("abort_busy", int'(busy[0]), 0);
    check("abort_hits", int'(hc0), 0);
    check("abort_seq_en", int'(seq_en[0]), 0);
    check("abort_seq_out", int'(seq_out[0]), 0);
    check("abort_done", int'(done[0]), 0);
    rst = 1'b1;
    tick(80);
    check("done_count", done_cnt, runs);
    check("stray_en", stray, 0);
    check("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
